// File: rtl/ir_pkg.sv
// Shared types and helpers for the IR receive capture block.
package ir_pkg;

  localparam int unsigned IR_CNT_WIDTH_DEF = 16;
  localparam int unsigned IR_DEPTH_DEF     = 8;

  typedef struct packed {
    logic                        level;
    logic                        timeout;
    logic [IR_CNT_WIDTH_DEF-1:0] dur;
  } ir_rec_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
    return (val >= max) ? max : val + 32'd1;
  endfunction

endpackage

// File: rtl/ir_rec_fifo.sv
// Record FIFO: push/full write side, valid/ready read side, registered head
// with no write-to-read bypass.
module ir_rec_fifo #(
  parameter int unsigned W     = 18,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  output logic                       full,
  output logic                       drop,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          pop;
  logic          do_push;

  always_comb begin
    rd_valid = (count != '0);
    full     = (count == LW'(DEPTH));
    pop      = rd_valid && rd_ready;
    // a pop frees the slot in the same cycle, so a full FIFO still accepts
    do_push  = push && (!full || pop);
    drop     = push && full && !pop;
    rd_data  = mem[rd_ptr];
    level    = count;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !pop)      count <= count + LW'(1);
      else if (!do_push && pop) count <= count - LW'(1);
    end
  end

endmodule

// File: rtl/ir_rx_capture.sv
// IR receiver front end: sync, glitch filter, level-duration capture into a FIFO.
// Optional runt suppression enabled by defining IR_RX_CAPTURE_MIN_PULSE_EN.
module ir_rx_capture
  import ir_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = IR_CNT_WIDTH_DEF,
  parameter int unsigned DEPTH       = IR_DEPTH_DEF,
  parameter int unsigned FILT_CYCLES = 4,
  parameter int unsigned TIMEOUT     = 20000,
  parameter logic        IDLE_LEVEL  = 1'b0
`ifdef IR_RX_CAPTURE_MIN_PULSE_EN
  , parameter int unsigned MIN_DUR   = 8
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx,
  output logic                       pulse,
  output logic                       rx_edge,
  output logic [CNT_WIDTH-1:0]       cnt,
  output logic                       frame_end,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_level,
  output logic [CNT_WIDTH-1:0]       out_dur,
  output logic                       out_timeout,
  output logic                       overflow,
  input  logic                       clr_ovf,
  output logic [$clog2(DEPTH+1)-1:0] level
`ifdef IR_RX_CAPTURE_MIN_PULSE_EN
  , output logic [7:0]               runt_cnt
`endif
);

  localparam int unsigned FW    = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam int unsigned REC_W = CNT_WIDTH + 2;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                 rx_m;
  logic                 rx_s;
  logic [FW-1:0]        filt_cnt;
  logic                 armed;
  logic                 accept;
  logic                 timeout_fire;
  logic                 edge_push;
  logic                 push;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [REC_W-1:0]     push_data;
  logic                 full;
  logic                 drop;

  always_comb begin
    cnt_inc      = CNT_WIDTH'(sat_inc(32'(cnt), 32'(CNT_MAX)));
    accept       = (rx_s != pulse) && (filt_cnt == FW'(FILT_CYCLES - 1));
    // an accept on the timeout cycle wins, so the two never push together
    timeout_fire = armed && (pulse == IDLE_LEVEL) && !accept
                   && (cnt == CNT_WIDTH'(TIMEOUT - 1));
`ifdef IR_RX_CAPTURE_MIN_PULSE_EN
    edge_push    = accept && (cnt_inc >= CNT_WIDTH'(MIN_DUR));
`else
    edge_push    = accept;
`endif
    push         = edge_push || timeout_fire;
    push_data    = timeout_fire ? {IDLE_LEVEL, 1'b1, CNT_WIDTH'(TIMEOUT)}
                                : {pulse, 1'b0, cnt_inc};
    rx_edge      = accept;
    frame_end    = timeout_fire;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m     <= IDLE_LEVEL;
      rx_s     <= IDLE_LEVEL;
      pulse    <= IDLE_LEVEL;
      filt_cnt <= '0;
      cnt      <= '0;
      armed    <= 1'b0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      if (accept) begin
        pulse    <= ~pulse;
        filt_cnt <= '0;
        cnt      <= '0;
        armed    <= 1'b1;
      end else begin
        cnt      <= cnt_inc;
        filt_cnt <= (rx_s != pulse) ? filt_cnt + FW'(1) : '0;
        if (timeout_fire) armed <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

`ifdef IR_RX_CAPTURE_MIN_PULSE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   runt_cnt <= '0;
    else if (accept && !edge_push) runt_cnt <= 8'(sat_inc(32'(runt_cnt), 32'd255));
  end
`endif

  ir_rec_fifo #(
    .W     (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .full      (full),
    .drop      (drop),
    .rd_valid  (out_valid),
    .rd_ready  (out_ready),
    .rd_data   ({out_level, out_timeout, out_dur}),
    .level     (level)
  );

endmodule

// File: tb/tb_ir_rx_capture.sv
// Directed bench for ir_rx_capture (CNT_WIDTH=16, DEPTH=4, FILT_CYCLES=3, TIMEOUT=1000).
module tb_ir_rx_capture;
  import ir_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        pulse;
  logic        rx_edge;
  logic [15:0] cnt;
  logic        frame_end;
  logic        out_valid;
  logic        out_ready;
  logic        out_level;
  logic [15:0] out_dur;
  logic        out_timeout;
  logic        overflow;
  logic        clr_ovf;
  logic [2:0]  level;
`ifdef IR_RX_CAPTURE_MIN_PULSE_EN
  logic [7:0]  runt_cnt;
`endif

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned n_edge  = 0;
  int unsigned n_fe    = 0;
  int unsigned c       = 0;
  ir_rec_t     got[$];

  ir_rx_capture #(
    .CNT_WIDTH   (16),
    .DEPTH       (4),
    .FILT_CYCLES (3),
    .TIMEOUT     (1000),
    .IDLE_LEVEL  (1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .pulse       (pulse),
    .rx_edge     (rx_edge),
    .cnt         (cnt),
    .frame_end   (frame_end),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_level   (out_level),
    .out_dur     (out_dur),
    .out_timeout (out_timeout),
    .overflow    (overflow),
    .clr_ovf     (clr_ovf),
    .level       (level)
`ifdef IR_RX_CAPTURE_MIN_PULSE_EN
    , .runt_cnt  (runt_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic ir_rec_t rec(input logic l, input logic t, input logic [15:0] d);
    ir_rec_t r;
    r.level   = l;
    r.timeout = t;
    r.dur     = d;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance n cycles; outputs are sampled 1 time unit after each posedge.
  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      if (out_valid && out_ready) got.push_back(rec(out_level, out_timeout, out_dur));
      if (rx_edge)   n_edge++;
      if (frame_end) n_fe++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; rx = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    step(3);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_pulse",     64'(pulse),     64'(0));
    check("rst_cnt",       64'(cnt),       64'(0));
    check("rst_level",     64'(level),     64'(0));
    check("rst_overflow",  64'(overflow),  64'(0));
    check("rst_frame_end", 64'(frame_end), 64'(0));

    // clean burst
    rst = 1'b0; out_ready = 1'b1;
    step(10);
    check("cnt_after_release", 64'(cnt), 64'(10));
    rx = 1'b1; step(100);
    rx = 1'b0; step(50);
    rx = 1'b1; step(100);
    rx = 1'b0; step(1100);
    check("burst_nrec", 64'(got.size()), 64'(5));
    check("burst_rec0", 64'(got[0]), 64'(rec(1'b0, 1'b0, 16'd15)));
    check("burst_rec1", 64'(got[1]), 64'(rec(1'b1, 1'b0, 16'd100)));
    check("burst_rec2", 64'(got[2]), 64'(rec(1'b0, 1'b0, 16'd50)));
    check("burst_rec3", 64'(got[3]), 64'(rec(1'b1, 1'b0, 16'd100)));
    check("burst_rec4", 64'(got[4]), 64'(rec(1'b0, 1'b1, 16'd1000)));
    check("burst_edges", 64'(n_edge), 64'(4));
    check("burst_frame_end", 64'(n_fe), 64'(1));

    // glitch rejection
    got.delete(); n_edge = 0; c = 32'(cnt);
    rx = 1'b1; step(2);
    rx = 1'b0; step(20);
    check("glitch2_edges", 64'(n_edge), 64'(0));
    check("glitch2_nrec",  64'(got.size()), 64'(0));
    check("glitch2_cnt",   64'(cnt), 64'(c + 22));
    c = 32'(cnt);
    rx = 1'b1; step(3);
    check("blip3_no_edge_yet", 64'(rx_edge), 64'(0));
    rx = 1'b0; step(1);
    check("blip3_edge", 64'(rx_edge), 64'(1));
    step(1);
    check("blip3_pulse", 64'(pulse), 64'(1));
    check("blip3_cnt",   64'(cnt),   64'(0));
    step(1100);
    check("blip3_nrec", 64'(got.size()), 64'(3));
    check("blip3_rec0", 64'(got[0]), 64'(rec(1'b0, 1'b0, 16'(c + 5))));
    check("blip3_rec1", 64'(got[1]), 64'(rec(1'b1, 1'b0, 16'd3)));
    check("blip3_rec2", 64'(got[2]), 64'(rec(1'b0, 1'b1, 16'd1000)));

    // overflow with consumer stalled
    got.delete(); out_ready = 1'b0; c = 32'(cnt);
    for (int k = 0; k < 6; k++) begin
      rx = ~rx;
      step(10);
    end
    check("ovf_level",    64'(level),    64'(4));
    check("ovf_sticky",   64'(overflow), 64'(1));
    check("ovf_valid",    64'(out_valid), 64'(1));
    check("ovf_head",     64'({out_level, out_timeout, out_dur}), 64'(rec(1'b0, 1'b0, 16'(c + 5))));
    clr_ovf = 1'b1; step(1); clr_ovf = 1'b0;
    check("ovf_clear", 64'(overflow), 64'(0));
    rx = 1'b1; step(4);
    clr_ovf = 1'b1; step(1); clr_ovf = 1'b0;
    check("ovf_drop_beats_clear", 64'(overflow), 64'(1));
    step(5);
    clr_ovf = 1'b1; step(1); clr_ovf = 1'b0;

    // full FIFO with pop on the push cycle
    rx = 1'b0; step(4);
    check("fullpop_edge", 64'(rx_edge), 64'(1));
    out_ready = 1'b1; step(1); out_ready = 1'b0;
    check("fullpop_level",    64'(level),    64'(4));
    check("fullpop_overflow", 64'(overflow), 64'(0));
    out_ready = 1'b1; step(6);
    check("fullpop_nrec", 64'(got.size()), 64'(5));
    check("fullpop_rec0", 64'(got[0]), 64'(rec(1'b0, 1'b0, 16'(c + 5))));
    check("fullpop_rec1", 64'(got[1]), 64'(rec(1'b1, 1'b0, 16'd10)));
    check("fullpop_rec2", 64'(got[2]), 64'(rec(1'b0, 1'b0, 16'd10)));
    check("fullpop_rec3", 64'(got[3]), 64'(rec(1'b1, 1'b0, 16'd10)));
    check("fullpop_rec4", 64'(got[4]), 64'(rec(1'b1, 1'b0, 16'd11)));
    check("fullpop_drained", 64'(level), 64'(0));

    // counter saturation over a long idle
    got.delete(); n_fe = 0;
    step(66000);
    check("sat_cnt",       64'(cnt), 64'(65535));
    check("sat_nrec",      64'(got.size()), 64'(1));
    check("sat_timeout",   64'(got[0]), 64'(rec(1'b0, 1'b1, 16'd1000)));
    check("sat_frame_end", 64'(n_fe), 64'(1));
    rx = 1'b1; step(8);
    check("sat_nrec2",  64'(got.size()), 64'(2));
    check("sat_edgerec", 64'(got[1]), 64'(rec(1'b0, 1'b0, 16'd65535)));

    // reset in the middle of a frame
    out_ready = 1'b0; got.delete();
    rx = 1'b0; step(10);
    rx = 1'b1; step(10);
    check("mid_level", 64'(level), 64'(2));
    check("mid_pulse", 64'(pulse), 64'(1));
    rst = 1'b1; rx = 1'b0;
    #2;
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_pulse", 64'(pulse),     64'(0));
    check("mid_rst_cnt",   64'(cnt),       64'(0));
    check("mid_rst_level", 64'(level),     64'(0));
    step(3);
    rst = 1'b0; n_fe = 0;
    step(1200);
    check("post_rst_no_timeout", 64'(n_fe), 64'(0));
    check("post_rst_cnt",        64'(cnt),  64'(1200));
    check("post_rst_valid",      64'(out_valid), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
